// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) followed by opcode-dependent execute
// steps (T3-T5) that drive datapath strobes for a simple register-transfer CPU.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  input  logic        Stop,
  output logic        PCout,
  output logic        IncPC,
  output logic        Zin,
  output logic        MARin,
  output logic        Zlowout,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        NEG,
  output logic        NOT,
  output logic        Run,
  output logic        Illegal
);

  typedef enum logic [2:0] {RST, T0, T1, T2, T3, T4, T5, HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT, OP_NOP, OP_HALT, OP_ILL
  } op_t;

  function automatic op_t decode_op(input logic [4:0] opc);
    case (opc)
      5'b00011: decode_op = OP_ADD;
      5'b00100: decode_op = OP_SUB;
      5'b00101: decode_op = OP_AND;
      5'b00110: decode_op = OP_OR;
      5'b10001: decode_op = OP_NEG;
      5'b10010: decode_op = OP_NOT;
      5'b11010: decode_op = OP_NOP;
      5'b11011: decode_op = OP_HALT;
      default:  decode_op = OP_ILL;
    endcase
  endfunction

  state_t state_q, state_d;
  op_t    op_q, op_d;
  logic   run_q, run_d;
  logic   illegal_q, illegal_d;
  op_t    cur_op;
  logic   three_reg, two_reg, alu_en;
  logic   unused_ir;

  assign unused_ir = ^IR[26:0];

  // IR is only valid from T3 on; T4/T5 reuse the class captured when leaving T3.
  assign cur_op    = (state_q == T3) ? decode_op(IR[31:27]) : op_q;
  assign three_reg = cur_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign two_reg   = cur_op inside {OP_NEG, OP_NOT};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    case (state_q)
      RST: state_d = T0;
      T0:  state_d = T1;
      T1:  if (Mem_ready) state_d = T2;
      T2:  state_d = T3;
      T3: begin
        op_d = cur_op;
        if (three_reg || two_reg) begin
          state_d = T4;
        end else if (cur_op == OP_NOP) begin
          state_d = Stop ? HALT : T0;
        end else if (cur_op == OP_HALT) begin
          state_d = HALT;
        end else begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end
      end
      T4: begin
        if (two_reg) state_d = Stop ? HALT : T0;
        else         state_d = T5;
      end
      T5:      state_d = Stop ? HALT : T0;
      HALT:    state_d = HALT;
      default: state_d = RST;
    endcase
    run_d = state_d inside {T0, T1, T2, T3, T4, T5};
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= RST;
      op_q      <= OP_NOP;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      run_q     <= run_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    PCout   = 1'b0;
    IncPC   = 1'b0;
    Zin     = 1'b0;
    MARin   = 1'b0;
    Zlowout = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    alu_en  = 1'b0;
    case (state_q)
      T0: begin
        PCout = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
        MARin = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (three_reg) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (two_reg) begin
          Grb    = 1'b1;
          Rout   = 1'b1;
          Zin    = 1'b1;
          alu_en = 1'b1;
        end
      end
      T4: begin
        if (three_reg) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          Zin    = 1'b1;
          alu_en = 1'b1;
        end else if (two_reg) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end
      end
      T5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign ADD     = alu_en && (cur_op == OP_ADD);
  assign SUB     = alu_en && (cur_op == OP_SUB);
  assign AND     = alu_en && (cur_op == OP_AND);
  assign OR      = alu_en && (cur_op == OP_OR);
  assign NEG     = alu_en && (cur_op == OP_NEG);
  assign NOT     = alu_en && (cur_op == OP_NOT);
  assign Run     = run_q;
  assign Illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an instruction-step model.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, Mem_ready, Stop;
  logic [31:0] IR;
  logic PCout, IncPC, Zin, MARin, Zlowout, Read, MDRin, MDRout, IRin, Yin;
  logic Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR, NEG, NOT, Run, Illegal;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .IncPC(IncPC), .Zin(Zin), .MARin(MARin), .Zlowout(Zlowout),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .NEG(NEG), .NOT(NOT),
    .Run(Run), .Illegal(Illegal)
  );

  always #5 clock = ~clock;

  logic [20:0] dut_s;
  assign dut_s = {PCout, IncPC, Zin, MARin, Zlowout, Read, MDRin, MDRout, IRin, Yin,
                  Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR, NEG, NOT};

  localparam logic [20:0] B_PCOUT = 21'h1 << 20, B_INCPC = 21'h1 << 19,
    B_ZIN = 21'h1 << 18, B_MARIN = 21'h1 << 17, B_ZLOW = 21'h1 << 16,
    B_READ = 21'h1 << 15, B_MDRIN = 21'h1 << 14, B_MDROUT = 21'h1 << 13,
    B_IRIN = 21'h1 << 12, B_YIN = 21'h1 << 11, B_GRA = 21'h1 << 10,
    B_GRB = 21'h1 << 9, B_GRC = 21'h1 << 8, B_RIN = 21'h1 << 7, B_ROUT = 21'h1 << 6,
    B_ADD = 21'h1 << 5, B_SUB = 21'h1 << 4, B_AND = 21'h1 << 3, B_NEG = 21'h1 << 1;
  localparam logic [20:0] S_FETCH = B_PCOUT | B_INCPC | B_ZIN | B_MARIN;
  localparam logic [20:0] S_READ  = B_ZLOW | B_READ | B_MDRIN;
  localparam logic [20:0] S_IRLD  = B_MDROUT | B_IRIN;
  localparam logic [20:0] S_WBACK = B_ZLOW | B_GRA | B_RIN;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Instruction classes: 1..4 three-register (ADD,SUB,AND,OR), 5..6 two-register
  // (NEG,NOT), 7 NOP, 8 HALT, 9 illegal.
  function automatic int classify(input logic [4:0] opc);
    case (opc)
      5'd3: return 1;
      5'd4: return 2;
      5'd5: return 3;
      5'd6: return 4;
      5'd17: return 5;
      5'd18: return 6;
      5'd26: return 7;
      5'd27: return 8;
      default: return 9;
    endcase
  endfunction

  function automatic int exec_len(input int k);
    if (k <= 4) return 3;
    if (k <= 6) return 2;
    return 1;
  endfunction

  function automatic logic [20:0] step_strobes(input int step, input int k);
    logic [20:0] alu;
    alu = (k >= 1 && k <= 6) ? (21'h1 << (6 - k)) : '0;
    if (step == 0) return S_FETCH;
    if (step == 1) return S_READ;
    if (step == 2) return S_IRLD;
    if (k <= 4) begin
      if (step == 3) return B_GRB | B_ROUT | B_YIN;
      if (step == 4) return B_GRC | B_ROUT | alu | B_ZIN;
      return S_WBACK;
    end
    if (k <= 6) begin
      if (step == 3) return B_GRB | B_ROUT | alu | B_ZIN;
      return S_WBACK;
    end
    return '0;
  endfunction

  // Model: mode 0 = reset cycle, 1 = executing, 2 = halted.
  int m_mode = 0, m_step = 0, m_k = 7;
  bit m_ill = 0;

  always @(posedge clock) begin
    if (clear) begin
      m_mode = 0;
      m_ill  = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_step = 0;
    end else if (m_mode == 1) begin
      if (m_step == 1) begin
        if (Mem_ready) m_step = 2;
      end else if (m_step < 3) begin
        m_step = m_step + 1;
      end else begin
        if (m_step == 3) m_k = classify(IR[31:27]);
        if (m_step == 3 && m_k == 9) begin
          m_ill  = 1;
          m_mode = 2;
        end else if (m_step == 3 && m_k == 8) begin
          m_mode = 2;
        end else if (m_step - 3 == exec_len(m_k) - 1) begin
          m_mode = Stop ? 2 : 1;
          m_step = 0;
        end else begin
          m_step = m_step + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic [20:0] es;
      int k_now;
      k_now = (m_step == 3) ? classify(IR[31:27]) : m_k;
      es = (m_mode == 1) ? step_strobes(m_step, k_now) : '0;
      checks++;
      if (dut_s !== es || Run !== (m_mode == 1) || Illegal !== m_ill) begin
        errors++;
        $display("FAIL model t=%0t strobes=%h run=%b ill=%b expected strobes=%h run=%b ill=%b",
                 $time, dut_s, Run, Illegal, es, (m_mode == 1), m_ill);
      end
    end
  end

  task automatic tick_chk(input string nm, input logic [20:0] es, input logic er,
                          input logic ei);
    @(negedge clock);
    #1;
    checks++;
    if (dut_s !== es || Run !== er || Illegal !== ei) begin
      errors++;
      $display("FAIL %s strobes=%h run=%b ill=%b expected strobes=%h run=%b ill=%b",
               nm, dut_s, Run, Illegal, es, er, ei);
    end
  endtask

  initial begin
    int halt_cnt;
    logic [4:0] opc;
    logic [4:0] optab [8];
    optab = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd17, 5'd18, 5'd26, 5'd27};
    clear = 1; Stop = 0; Mem_ready = 1; IR = 32'h2800_0000;
    @(negedge clock);
    #1 chk_en = 1;
    tick_chk("rst", '0, 0, 0);
    clear = 0;
    tick_chk("and_t0", S_FETCH, 1, 0);
    tick_chk("and_t1", S_READ, 1, 0);
    tick_chk("and_t2", S_IRLD, 1, 0);
    tick_chk("and_t3", B_GRB | B_ROUT | B_YIN, 1, 0);
    tick_chk("and_t4", B_GRC | B_ROUT | B_AND | B_ZIN, 1, 0);
    tick_chk("and_t5", S_WBACK, 1, 0);
    tick_chk("and_next_t0", S_FETCH, 1, 0);
    IR = 32'h8800_0000;
    tick_chk("neg_t1", S_READ, 1, 0);
    tick_chk("neg_t2", S_IRLD, 1, 0);
    tick_chk("neg_t3", B_GRB | B_ROUT | B_NEG | B_ZIN, 1, 0);
    tick_chk("neg_t4", S_WBACK, 1, 0);
    tick_chk("neg_next_t0", S_FETCH, 1, 0);
    IR = 32'hD000_0000; Mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick_chk("wait_t1", S_READ, 1, 0);
      if (i == 3) Mem_ready = 1;
    end
    tick_chk("wait_t2", S_IRLD, 1, 0);
    tick_chk("nop_t3", '0, 1, 0);
    tick_chk("nop_next_t0", S_FETCH, 1, 0);
    IR = 32'h1800_0000; Stop = 1;
    tick_chk("add_t1", S_READ, 1, 0);
    tick_chk("add_t2", S_IRLD, 1, 0);
    tick_chk("add_t3", B_GRB | B_ROUT | B_YIN, 1, 0);
    tick_chk("add_t4", B_GRC | B_ROUT | B_ADD | B_ZIN, 1, 0);
    tick_chk("add_t5", S_WBACK, 1, 0);
    tick_chk("stop_halt", '0, 0, 0);
    clear = 1; Stop = 0; IR = 32'h2000_0000;
    tick_chk("halt_clr_rst", '0, 0, 0);
    clear = 0;
    tick_chk("sub_t0", S_FETCH, 1, 0);
    tick_chk("sub_t1", S_READ, 1, 0);
    tick_chk("sub_t2", S_IRLD, 1, 0);
    tick_chk("sub_t3", B_GRB | B_ROUT | B_YIN, 1, 0);
    tick_chk("sub_t4", B_GRC | B_ROUT | B_SUB | B_ZIN, 1, 0);
    clear = 1; IR = 32'hD000_0000;
    tick_chk("mid_clr_rst", '0, 0, 0);
    clear = 0;
    tick_chk("restart_t0", S_FETCH, 1, 0);
    tick_chk("restart_t1", S_READ, 1, 0);
    tick_chk("restart_t2", S_IRLD, 1, 0);
    tick_chk("restart_t3", '0, 1, 0);
    tick_chk("restart_next_t0", S_FETCH, 1, 0);
    IR = 32'hF800_0000;
    tick_chk("ill_t1", S_READ, 1, 0);
    tick_chk("ill_t2", S_IRLD, 1, 0);
    tick_chk("ill_t3", '0, 1, 0);
    for (int i = 0; i < 10; i++) tick_chk("ill_halt", '0, 0, 1);
    clear = 1;
    tick_chk("ill_clr", '0, 0, 0);
    clear = 0;

    halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      #1;
      halt_cnt  = (m_mode == 2) ? halt_cnt + 1 : 0;
      clear     = (halt_cnt > 6) || ($urandom % 60 == 0);
      Stop      = ($urandom % 6 == 0);
      Mem_ready = ($urandom % 3 != 0);
      if ($urandom % 5 == 0) begin
        case ($urandom % 12)
          8, 9:    opc = optab[$urandom % 4];
          10:      opc = 5'($urandom);
          11:      opc = 5'd26;
          default: opc = optab[$urandom % 8];
        endcase
        IR = {opc, 27'($urandom)};
      end
    end
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
